// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the sequential 32x32 multiplier controller.
// Holds the FSM state encoding and the captured-operand record.
package mul_seq_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            id;
    } op_t;

endpackage

// File: rtl/mul_seq_add64.sv
// Purpose: 64-bit unsigned adder shared by the shift-add multiplier datapath.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
module mul_seq_add64
    import mul_seq_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    output logic [PROD_W-1:0] s
);

    assign s = a + b;

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Purpose: two-requester round-robin front end for a 32-cycle shift-add 32x32 multiplier.
// Latency: accept in cycle T, res_valid first high in cycle T+33.
// Backpressure: result held in DONE until res_ready; no new request accepted until then.
module mul32_seq_ctrl
    import mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_p,
    output logic              res_id,
    output logic              busy
);

    state_t              state;
    op_t                 op;
    logic [PROD_W-1:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic                last_gnt;

    logic                gnt_id;
    logic                accept;
    logic [PROD_W-1:0]   addend;
    logic [PROD_W-1:0]   sum;

    // With both pending, favour the one not served last; reset leaves last_gnt=1 so req0 wins first.
    always_comb begin
        gnt_id = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_gnt;
        end
    end

    assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    assign addend = {{OP_W{1'b0}}, op.a} << cnt;

    mul_seq_add64 u_add (
        .a (acc),
        .b (addend),
        .s (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            acc      <= '0;
            cnt      <= '0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op.a     <= gnt_id ? req1_a : req0_a;
                        op.b     <= gnt_id ? req1_b : req0_b;
                        op.id    <= gnt_id;
                        acc      <= '0;
                        cnt      <= '0;
                        last_gnt <= gnt_id;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (op.b[cnt]) begin
                        acc <= sum;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(OP_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign res_p     = acc;
    assign res_id    = op.id;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl with a cycle-level reference model of the
// request/result protocol checked every cycle, plus literal expected products.
module tb_mul32_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [63:0] res_p;
    logic        res_id;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    mul32_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_p      (res_p),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a 33-cycle wait after acceptance, then a
    // result that stays up until res_ready; products come from plain multiplication.
    bit          m_busy = 0;
    int          m_left = 0;
    bit          m_last = 1;
    logic [63:0] m_p    = '0;
    bit          m_id   = 0;

    function automatic bit grant_one(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_left = 0; m_last = 1; m_p = '0; m_id = 0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_id   = grant_one(req0_valid, req1_valid, m_last);
                m_last = m_id;
                m_p    = m_id ? (64'(req1_a) * 64'(req1_b)) : (64'(req0_a) * 64'(req0_b));
                m_busy = 1;
                m_left = 32;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (res_ready) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit can_go, g;
            can_go = rst_n && !m_busy && (req0_valid || req1_valid);
            g      = grant_one(req0_valid, req1_valid, m_last);
            chk("req0_ready", 64'(req0_ready), 64'(can_go && !g));
            chk("req1_ready", 64'(req1_ready), 64'(can_go && g));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("res_valid", 64'(res_valid), 64'(m_busy && m_left == 0));
            if (!m_busy || m_left == 0) begin
                chk("res_p", res_p, m_p);
                chk("res_id", 64'(res_id), 64'(m_id));
            end
        end
    end

    task automatic wait_accept(output int who);
        who = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                who = req1_ready ? 1 : 0;
                break;
            end
        end
        if (who < 0) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid(output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("result_timeout", 64'd0, 64'd1);
    endtask

    // Issue one request, scramble operands after acceptance, check literal result.
    task automatic do_op(input int which, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p);
        int who, lat;
        if (which == 0) begin req0_a = a; req0_b = b; req0_valid = 1; end
        else            begin req1_a = a; req1_b = b; req1_valid = 1; end
        wait_accept(who);
        chk("grant_id", 64'(who), 64'(which));
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        req0_a = ~a; req0_b = b ^ 32'h5a5a5a5a;
        req1_a = ~a; req1_b = b ^ 32'ha5a5a5a5;
        wait_valid(lat);
        chk("latency", 64'(lat), 64'd33);
        chk("product", res_p, exp_p);
        chk("owner", 64'(res_id), 64'(which));
        @(posedge clk); #1;
    endtask

    int who, lat, nres;
    logic [63:0] held_p;

    initial begin
        rst_n = 0; res_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_res_p", res_p, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        do_op(0, 32'd3, 32'd5, 64'd15);
        do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        do_op(0, 32'd0, 32'h12345678, 64'd0);

        // Round-robin from reset with both requesters always pending.
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        req0_a = 32'd7;      req0_b = 32'd9;
        req1_a = 32'd100000; req1_b = 32'd3;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            wait_accept(who);
            chk("rr_order", 64'(who), 64'(i % 2));
            @(posedge clk); #1;
            if (i == 3) begin req0_valid = 0; req1_valid = 0; end
            wait_valid(lat);
            chk("rr_res_id", 64'(res_id), 64'(i % 2));
            chk("rr_res_p", res_p, (i % 2) ? 64'd300000 : 64'd63);
            @(posedge clk); #1;
        end

        // Consumer stall in DONE.
        res_ready = 0;
        req0_a = 32'hDEADBEEF; req0_b = 32'h10; req0_valid = 1;
        wait_accept(who);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 1;
        wait_valid(lat);
        held_p = res_p;
        chk("stall_p_first", held_p, 64'h0000000DEADBEEF0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_p", res_p, 64'h0000000DEADBEEF0);
            chk("stall_id", 64'(res_id), 64'd0);
            chk("stall_ready1", 64'(req1_ready), 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1; req1_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_busy", 64'(busy), 64'd0);
        chk("post_hs_valid", 64'(res_valid), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        req0_a = 32'h1234; req0_b = 32'hFFFF; req0_valid = 1;
        wait_accept(who);
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_p", res_p, 64'd0);
        chk("mid_rst_id", 64'(res_id), 64'd0);
        nres = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (res_valid) nres++;
        end
        chk("no_result_after_reset", 64'(nres), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul32_seq_ctrl.md
MUL32_SEQ_CTRL -- requirements
Module: mul32_seq_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, product width at 64 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req0_valid  in  1  requester 0 has operands pending.
REQ-005 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-006 req0_a / req0_b  in  32 each  requester 0 multiplicand / multiplier.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006, for requester 1.
REQ-008 res_valid  out  1  product available.
REQ-009 res_ready  in  1  consumer accepts product.
REQ-010 res_p  out  64  unsigned product A*B.
REQ-011 res_id  out  1  requester index that owns res_p.
REQ-012 busy  out  1  high in RUN and DONE states.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: when any reqN_valid=1, the block SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, capture A, B and id, clear the accumulator and counter, then go to RUN.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; after reset requester 0 has priority.
REQ-016 reqN_ready SHALL be 0 in RUN and DONE, and 0 in IDLE for a non-granted requester.
REQ-017 RUN: on each of exactly 32 cycles k=0..31, if B[k]=1 the accumulator SHALL add {32'b0,A}<<k using the shared 64-bit adder; otherwise it holds.
REQ-018 After cycle k=31 the FSM SHALL go to DONE; there is no early termination (a zero operand still takes 32 cycles).
REQ-019 Latency: handshake in cycle T -> res_valid=1 first in cycle T+33.
REQ-020 DONE: res_valid=1; res_p and res_id SHALL be stable until res_valid&&res_ready.
REQ-021 On result handshake in cycle D: go to IDLE at D+1 with res_valid=0. A new request can be accepted at D+1.
REQ-022 Arithmetic: result is exact (32x32 unsigned fits in 64 bits); no overflow or truncation is permitted.
REQ-023 Operands SHALL be sampled only at the accept handshake; later input changes have no effect on the operation in flight.
REQ-024 res_p SHALL retain its last value in IDLE; res_valid is the only qualifier.

Reset
REQ-025 rst_n=0 at any edge SHALL force: state=IDLE, req0_ready=req1_ready=0, res_valid=0, res_p=0, res_id=0, busy=0, counter=0, round-robin pointer to favour requester 0.
REQ-026 Reset during RUN or DONE SHALL discard the operation in flight; no result is ever presented for it.
REQ-027 reqN_ready SHALL be 0 while rst_n=0.

Structure
REQ-028 Shared package mul_seq_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constants OP_W=32, PROD_W=64, CNT_W=5.
REQ-029 The 64-bit adder SHALL be a separate combinational sub-module, mul_seq_add64 (S=A+B, 64-bit), instantiated once.
REQ-030 The 64-bit accumulator, 5-bit counter, captured A/B/id and the 1-bit last-grant pointer SHALL be the only state.

Verification
REQ-031 req0: A=3, B=5, accepted at T -> res_valid at T+33, res_p=15, res_id=0.
REQ-032 req1: A=B=0xFFFFFFFF -> res_p=0xFFFFFFFE00000001, res_id=1.
REQ-033 Both requesters hold valid through four operations with res_ready=1 -> grant order is 0,1,0,1, and res_id matches that order.
REQ-034 res_ready held 0 for 5 cycles in DONE -> res_valid, res_p and res_id stay stable, reqN_ready stays 0; the handshake then completes and the FSM is in IDLE next cycle.
REQ-035 rst_n=0 for one cycle at RUN k=10 -> all outputs at reset values next cycle, and no res_valid follows for that operation.
REQ-036 A=0, B=0x12345678 -> res_p=0 after exactly 33 cycles; change req0_a/req0_b after the handshake -> result is unchanged.
